// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   NUM_PORTS   : number of requester ports
//   ERR_DATA    : read data returned to a requester on timeout
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int          NUM_PORTS = 2;
   localparam logic [31:0] ERR_DATA  = 32'h0;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req        : request vector, bit n = port n
//   last_grant : index of the port that owned the previous transaction
//   grant      : one-hot winner, 0 when nobody requests
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic                 last_grant,
   output logic [NUM_PORTS-1:0] grant
);

   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // contention: the port that did not win last time goes next
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one variable-latency memory between the CPU
// load/store port (port 0) and the loader/DMA port (port 1). One
// transaction in flight at a time, round-robin grants, timeout abort.
//   clk, reset        : clock and async active-low reset
//   m0_* / m1_*       : requester ports (req/we/addr/wdata in, ack/err/rdata out)
//   mem_*             : memory side (req/we/addr/wdata out, ack/rdata in)
//   busy, grant       : status; grant is the one-hot owner, 0 in IDLE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transaction; arbitrate requests each cycle
// BUSY  | mem_req held with latched fields, waiting for mem_ack/timeout
// RESP  | one-cycle ack (and err on timeout) to the granted port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        grant
);

   // Timeout fires at the end of the TIMEOUT-th BUSY cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t                 state;
   logic [7:0]                 cnt;
   logic                       last_grant;
   logic [NUM_PORTS-1:0]       pick;
   logic                       timed_out;

   rr_arbiter2 u_rr (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .grant      (pick)
   );

   // mem_ack takes priority over a timeout firing in the same cycle
   assign timed_out = !mem_ack && (cnt >= TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
         grant      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= '0;
      end else begin
         m0_ack <= 1'b0;
         m0_err <= 1'b0;
         m1_ack <= 1'b0;
         m1_err <= 1'b0;
         case (state)
            IDLE: begin
               if (pick != '0) begin
                  state      <= BUSY;
                  busy       <= 1'b1;
                  grant      <= pick;
                  last_grant <= pick[1];
                  cnt        <= '0;
                  mem_req    <= 1'b1;
                  mem_we     <= pick[1] ? m1_we    : m0_we;
                  mem_addr   <= pick[1] ? m1_addr  : m0_addr;
                  mem_wdata  <= pick[1] ? m1_wdata : m0_wdata;
               end
            end
            BUSY: begin
               if (cnt != 8'hFF) cnt <= cnt + 8'd1;
               if (mem_ack || timed_out) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  m0_ack  <= grant[0];
                  m1_ack  <= grant[1];
                  m0_err  <= grant[0] & timed_out;
                  m1_err  <= grant[1] & timed_out;
                  if (timed_out) begin
                     if (grant[0]) m0_rdata <= DATA_W'(ERR_DATA);
                     if (grant[1]) m1_rdata <= DATA_W'(ERR_DATA);
                  end else if (!mem_we) begin
                     if (grant[0]) m0_rdata <= mem_rdata;
                     if (grant[1]) m1_rdata <= mem_rdata;
                  end
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               grant <= '0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               grant   <= '0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
